// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Summary  : Game score counter with tick divider, saturation and high score.
// Revision : 1.0
// ============================================================================
module score_keeper #(
  parameter int SCORE_W   = 10,
  parameter int SCORE_MAX = 999,
  parameter int TICK_DIV  = 50
) (
  input  logic               clk2,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               running,
  output logic               game_over,
  output logic [3:0]         speed_level,
  output logic               new_record
);

  localparam int                 c_tick_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0]  c_score_sat = SCORE_W'(SCORE_MAX);

  localparam logic [1:0] c_s_idle = 2'd0;
  localparam logic [1:0] c_s_run  = 2'd1;
  localparam logic [1:0] c_s_over = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                start_q;
  logic [c_tick_w-1:0] tick_q, tick_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic                rec_q, rec_d;
  logic                w_start_edge;
  logic                w_tick_wrap;
  logic [3:0]          w_speed;

  assign w_start_edge = start & ~start_q;
  assign w_tick_wrap  = (tick_q == c_tick_last);

  // State register
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      state_q <= c_s_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_s_idle: if (w_start_edge) state_d = c_s_run;
      c_s_run:  if (hit)          state_d = c_s_over;
      c_s_over: if (w_start_edge) state_d = c_s_run;
      default:                    state_d = c_s_idle;
    endcase
  end

  // Output decode
  always_comb begin
    running   = (state_q == c_s_run);
    game_over = (state_q == c_s_over);
  end

  // Datapath next values; a hit in RUN takes priority over a tick wrap
  always_comb begin
    score_d = score_q;
    tick_d  = tick_q;
    high_d  = high_q;
    rec_d   = rec_q;
    case (state_q)
      c_s_idle, c_s_over: begin
        if (w_start_edge) begin
          score_d = '0;
          tick_d  = '0;
          rec_d   = 1'b0;
        end
      end
      c_s_run: begin
        if (hit) begin
          if (score_q > high_q) begin
            high_d = score_q;
            rec_d  = 1'b1;
          end else begin
            rec_d  = 1'b0;
          end
        end else if (w_tick_wrap) begin
          tick_d = '0;
          if (score_q < c_score_sat) score_d = score_q + SCORE_W'(1);
        end else begin
          tick_d = tick_q + c_tick_w'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      tick_q  <= '0;
      score_q <= '0;
      high_q  <= '0;
      rec_q   <= 1'b0;
    end else begin
      start_q <= start;
      tick_q  <= tick_d;
      score_q <= score_d;
      high_q  <= high_d;
      rec_q   <= rec_d;
    end
  end

  // Threshold ladder instead of a divider: level = number of hundreds reached, capped at 9
  always_comb begin
    w_speed = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (32'(score_q) >= 32'(k * 100)) w_speed = 4'(k);
    end
  end

  assign score       = score_q;
  assign high_score  = high_q;
  assign new_record  = rec_q;
  assign speed_level = w_speed;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_keeper
// Summary  : Self-checking bench for score_keeper (vector table, directed, random).
// Revision : 1.0
// ============================================================================
module tb_score_keeper;

  localparam int SW   = 10;
  localparam int SMAX = 999;
  localparam int TD   = 4;

  logic          clk2  = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          hit   = 1'b0;
  logic [SW-1:0] score;
  logic [SW-1:0] high_score;
  logic          running;
  logic          game_over;
  logic [3:0]    speed_level;
  logic          new_record;

  score_keeper #(.SCORE_W(SW), .SCORE_MAX(SMAX), .TICK_DIV(TD)) dut (
    .clk2        (clk2),
    .reset       (reset),
    .start       (start),
    .hit         (hit),
    .score       (score),
    .high_score  (high_score),
    .running     (running),
    .game_over   (game_over),
    .speed_level (speed_level),
    .new_record  (new_record)
  );

  always #5 clk2 = ~clk2;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle 1=run 2=over; score is derived from the
  // number of non-hit cycles spent running in the current game.
  int m_mode, m_n, m_hs;
  bit m_rec, m_prev;

  function automatic int m_score();
    int s;
    s = m_n / TD;
    return (s > SMAX) ? SMAX : s;
  endfunction

  function automatic int m_speed();
    int l;
    l = m_score() / 100;
    return (l > 9) ? 9 : l;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_hs = 0; m_rec = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit s, input bit h);
    bit edge_seen;
    int fin;
    edge_seen = s && !m_prev;
    case (m_mode)
      0: if (edge_seen) begin m_mode = 1; m_n = 0; end
      1: begin
        if (h) begin
          m_mode = 2;
          fin = m_score();
          if (fin > m_hs) begin m_hs = fin; m_rec = 1; end
          else m_rec = 0;
        end else begin
          m_n++;
        end
      end
      default: if (edge_seen) begin m_mode = 1; m_n = 0; m_rec = 0; end
    endcase
    m_prev = s;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, " running"},    32'(running),     32'(m_mode == 1));
    chk({tag, " game_over"},  32'(game_over),   32'(m_mode == 2));
    chk({tag, " score"},      32'(score),       32'(m_score()));
    chk({tag, " high_score"}, 32'(high_score),  32'(m_hs));
    chk({tag, " new_record"}, 32'(new_record),  32'(m_rec));
    chk({tag, " speed"},      32'(speed_level), 32'(m_speed()));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input bit s, input bit h);
    start = s;
    hit   = h;
    @(posedge clk2);
    model_step(s, h);
    @(negedge clk2);
  endtask

  task automatic run_n(input int n, input bit s, input bit h, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(s, h);
      compare_model(tag);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    hit   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk2);
    reset = 1'b1;
  endtask

  typedef struct {
    logic st;
    logic ht;
    logic run;
    logic ovr;
    int   sc;
    int   hs;
    logic rec;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0};

    // Reset state
    reset = 1'b0;
    model_reset();
    #2;
    chk("rst running",    32'(running),     0);
    chk("rst game_over",  32'(game_over),   0);
    chk("rst score",      32'(score),       0);
    chk("rst high_score", 32'(high_score),  0);
    chk("rst speed",      32'(speed_level), 0);
    chk("rst new_record", 32'(new_record),  0);
    repeat (2) @(negedge clk2);
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].st, tbl[i].ht);
      chk($sformatf("vec%0d running", i),    32'(running),    32'(tbl[i].run));
      chk($sformatf("vec%0d game_over", i),  32'(game_over),  32'(tbl[i].ovr));
      chk($sformatf("vec%0d score", i),      32'(score),      32'(tbl[i].sc));
      chk($sformatf("vec%0d high_score", i), 32'(high_score), 32'(tbl[i].hs));
      chk($sformatf("vec%0d new_record", i), 32'(new_record), 32'(tbl[i].rec));
    end

    // Basic count: one-cycle start pulse then 40 running cycles
    do_reset();
    drive(1'b1, 1'b0);
    run_n(40, 1'b0, 1'b0, "basic");
    chk("basic running", 32'(running),     1);
    chk("basic score",   32'(score),       10);
    chk("basic speed",   32'(speed_level), 0);

    // Held start: one transition only
    do_reset();
    run_n(100, 1'b1, 1'b0, "held");
    chk("held running", 32'(running), 1);
    chk("held score",   32'(score),   24);

    // Hit in the same cycle as the tick wrap
    do_reset();
    drive(1'b1, 1'b0);
    run_n(23, 1'b0, 1'b0, "coll");
    chk("coll pre score", 32'(score), 5);
    drive(1'b0, 1'b1);
    compare_model("coll hit");
    chk("coll score",     32'(score),     5);
    chk("coll game_over", 32'(game_over), 1);
    chk("coll running",   32'(running),   0);

    // Records: 12 (record), 7 (no), 12 (tie, no)
    do_reset();
    drive(1'b1, 1'b0);
    run_n(48, 1'b0, 1'b0, "g1");
    drive(1'b0, 1'b1);
    chk("g1 high_score", 32'(high_score), 12);
    chk("g1 new_record", 32'(new_record), 1);
    drive(1'b1, 1'b0);
    chk("g2 start clears record", 32'(new_record), 0);
    run_n(28, 1'b0, 1'b0, "g2");
    drive(1'b0, 1'b1);
    chk("g2 high_score", 32'(high_score), 12);
    chk("g2 new_record", 32'(new_record), 0);
    drive(1'b1, 1'b0);
    run_n(48, 1'b0, 1'b0, "g3");
    drive(1'b0, 1'b1);
    chk("g3 score",      32'(score),      12);
    chk("g3 high_score", 32'(high_score), 12);
    chk("g3 new_record", 32'(new_record), 0);
    run_n(5, 1'b0, 1'b1, "over hold");

    // Saturation
    drive(1'b1, 1'b0);
    run_n(4 * 1005, 1'b0, 1'b0, "sat");
    chk("sat score", 32'(score),       999);
    chk("sat speed", 32'(speed_level), 9);
    run_n(9, 1'b0, 1'b0, "sat hold");
    chk("sat hold score", 32'(score), 999);

    // Mid-game reset with score 57 and high score 30
    do_reset();
    drive(1'b1, 1'b0);
    run_n(120, 1'b0, 1'b0, "mr g1");
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    run_n(228, 1'b0, 1'b0, "mr g2");
    chk("mr pre score", 32'(score),      57);
    chk("mr pre high",  32'(high_score), 30);
    #2;
    reset = 1'b0;
    #1;
    chk("mr score",     32'(score),       0);
    chk("mr high",      32'(high_score),  0);
    chk("mr running",   32'(running),     0);
    chk("mr game_over", 32'(game_over),   0);
    chk("mr speed",     32'(speed_level), 0);
    chk("mr record",    32'(new_record),  0);
    model_reset();
    @(negedge clk2);
    @(negedge clk2);
    reset = 1'b1;
    run_n(4, 1'b0, 1'b0, "mr idle");
    chk("mr idle running", 32'(running), 0);
    run_n(4, 1'b0, 1'b1, "mr idle hit");
    drive(1'b1, 1'b0);
    chk("mr restart running", 32'(running), 1);

    // Randomized phases with varying hit density
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        bit s, h;
        s = ($urandom_range(0, 9) < 2);
        h = ($urandom_range(0, seg * 60 + 10) == 0);
        drive(s, h);
        compare_model($sformatf("rnd%0d", seg));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
